// File: rtl/alu_seq.sv
// Sequential ALU: registered single-cycle arithmetic/logic ops plus an iterative
// shifter that moves up to SHIFT_PER_CYCLE bit positions per clock behind a busy/done handshake.
module alu_seq #(
  parameter int WIDTH           = 8,
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             OVF_out,
  output logic             NZ_out,
  output logic             busy,
  output logic             done
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW:0] SPC = (KW+1)'(SHIFT_PER_CYCLE);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;
  localparam logic [3:0] OP_ADDK = 4'd5;
  localparam logic [3:0] OP_ANDB = 4'd6;
  localparam logic [3:0] OP_XORB = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;
  localparam logic [3:0] OP_ASR  = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  logic [0:0]       state;
  logic [WIDTH-1:0] work;
  logic [KW-1:0]    rem;
  logic [3:0]       sh_op;

  logic [KW-1:0]    k;
  logic             is_shift;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   sum_adc;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  logic [KW:0]      step_s;
  logic [KW-1:0]    rem_next;
  logic [WIDTH-1:0] step_res;
  logic             step_out;

  assign k        = in_b[KW-1:0];
  assign is_shift = (op >= OP_SHL) && (op <= OP_ASR);

  // Single-cycle result. Shifts by zero and op 0 fall through to A with the flag kept.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    res_d   = in_a;
    ovf_d   = OVF_out;
    sum_ab  = {1'b0, in_a} + {1'b0, in_b};
    sum_adc = sum_ab + {{WIDTH{1'b0}}, OVF_out};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    case (op)
      OP_ADD:          begin res_d = sum_ab[WIDTH-1:0];  ovf_d = sum_ab[WIDTH];  end
      OP_AND, OP_ANDB: res_d = in_a & in_b;
      OP_XOR, OP_XORB: res_d = in_a ^ in_b;
      OP_B:            res_d = in_b;
      OP_ADDK:         res_d = sum_ab[WIDTH-1:0];
      OP_ADC:          begin res_d = sum_adc[WIDTH-1:0]; ovf_d = sum_adc[WIDTH]; end
      OP_SUB:          begin res_d = diff[WIDTH-1:0];    ovf_d = diff[WIDTH];    end
      OP_OR:           res_d = in_a | in_b;
      default:         ;
    endcase
  end

  // One shifter step of up to SPC single-bit moves; step_out is the last bit that fell off.
  always_comb begin
    step_s   = ({1'b0, rem} > SPC) ? SPC : {1'b0, rem};
    rem_next = rem - step_s[KW-1:0];
    step_res = work;
    step_out = 1'b0;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (i < int'(step_s)) begin
        case (sh_op)
          OP_SHL: begin
            step_out = step_res[WIDTH-1];
            step_res = {step_res[WIDTH-2:0], 1'b0};
          end
          OP_SHR: begin
            step_out = step_res[0];
            step_res = {1'b0, step_res[WIDTH-1:1]};
          end
          OP_ROR:  step_res = {step_res[0], step_res[WIDTH-1:1]};
          default: step_res = {step_res[WIDTH-1], step_res[WIDTH-1:1]};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled at the clock edge; it also clears the shifter work registers so an aborted shift leaves nothing behind.
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      rem     <= '0;
      sh_op   <= '0;
      alu_out <= '0;
      OVF_out <= 1'b0;
      NZ_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      NZ_out <= (in_a != '0);
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && (k != '0)) begin
              work  <= in_a;
              rem   <= k;
              sh_op <= op;
              busy  <= 1'b1;
              state <= SHIFT;
            end else if (op != OP_NOP) begin
              alu_out <= res_d;
              OVF_out <= ovf_d;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          work <= step_res;
          rem  <= rem_next;
          if (rem_next == '0) begin
            alu_out <= step_res;
            if ((sh_op == OP_SHL) || (sh_op == OP_SHR)) OVF_out <= step_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results are queued at issue time by a reference
// model and popped when done pulses; a second instance with two shifts per cycle checks latency.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] op;
  logic [7:0] in_a, in_b;
  logic [7:0] alu_out, alu_out2;
  logic       ovf, ovf2, nz, nz2, busy, busy2, done, done2;

  exp_t q[$];
  logic model_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .SHIFT_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .alu_out(alu_out), .OVF_out(ovf), .NZ_out(nz), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8), .SHIFT_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .alu_out(alu_out2), .OVF_out(ovf2), .NZ_out(nz2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [3:0] o, input logic [7:0] a,
                                       input logic [7:0] b, input logic c);
    logic [8:0] t;
    int kk;
    kk = int'(b[2:0]);
    case (o)
      4'd1:       t = {1'b0, a} + {1'b0, b};
      4'd2, 4'd6: t = {c, a & b};
      4'd3, 4'd7: t = {c, a ^ b};
      4'd4:       t = {c, b};
      4'd5:       begin t = {1'b0, a} + {1'b0, b}; t[8] = c; end
      4'd8:       t = {1'b0, a} + {1'b0, b} + {8'd0, c};
      4'd9:       t = {(a < b), 8'(a - b)};
      4'd10:      t = {c, a | b};
      4'd11:      t = (kk == 0) ? {c, a} : {a[8-kk], 8'(a << kk)};
      4'd12:      t = (kk == 0) ? {c, a} : {a[kk-1], 8'(a >> kk)};
      4'd13:      t = {c, 8'((a >> kk) | (a << (8 - kk)))};
      4'd14:      t = {c, 8'($signed(a) >>> kk)};
      default:    t = {c, a};
    endcase
    return t;
  endfunction

  // Drives one start at a negedge, queues the expectation and returns at the next negedge.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = model(o, a, b, model_ovf);
    if (o != 4'd15) begin
      q.push_back('{res: t[7:0], ovf: t[8]});
      model_ovf = t[8];
    end
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, (q.size() > 0), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_res"}, alu_out, e.res);
      check({tag, "_ovf"}, ovf, e.ovf);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    pop_check(tag);
  endtask

  initial begin
    logic [3:0] lops [7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd10};
    int n, n2;
    rst_n = 1'b0; start = 1'b0; op = 4'd0; in_a = 8'h00; in_b = 8'h00;
    model_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_out", alu_out, 0);
    check("rst_flags", {ovf, nz, busy, done}, 0);
    rst_n = 1'b1;

    // Reset in the middle of a shift.
    issue(4'd11, 8'hFF, 8'h05);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_rst_out", alu_out, 0);
    check("mid_rst_flags", {ovf, nz, busy, done}, 0);
    q.delete();
    model_ovf = 1'b0;
    rst_n = 1'b1;
    issue(4'd4, 8'h00, 8'h5A);
    wait_done(0, "after_rst");

    // Add with carry-out, then add that keeps the flag.
    issue(4'd1, 8'hF0, 8'h20);
    wait_done(0, "add");
    @(negedge clk);
    check("done_pulse", done, 0);
    issue(4'd5, 8'h01, 8'h01);
    wait_done(0, "addk");

    // ADC uses the carry, SUB produces a borrow; issued back to back.
    issue(4'd8, 8'hFF, 8'h00);
    wait_done(0, "adc");
    issue(4'd9, 8'h03, 8'h05);
    wait_done(0, "sub");

    // NOP: no done, no write.
    issue(4'd15, 8'h12, 8'h34);
    check("nop_done", done, 0);
    check("nop_hold", alu_out, 8'hFE);

    // SHL by 3: three cycles at one bit per cycle, two cycles on the wider instance.
    issue(4'd11, 8'h81, 8'h03);
    check("shl_busy", busy, 1);
    check("shl_hold", alu_out, 8'hFE);
    n = 0; n2 = (done2 === 1'b1) ? 0 : -1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (done2 === 1'b1 && n2 < 0) n2 = n;
    end
    check("shl_lat", n, 3);
    check("shl_lat_spc2", n2, 2);
    check("shl_res_spc2", alu_out2, 8'h08);
    pop_check("shl");

    // Rotate, then a start during busy that must be dropped.
    issue(4'd13, 8'h01, 8'h01);
    wait_done(1, "ror1");
    issue(4'd13, 8'h01, 8'h04);
    start = 1'b1; op = 4'd4; in_b = 8'h77;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, "ror4");
    @(negedge clk);
    check("ignored_start", {done, busy}, 0);
    issue(4'd12, 8'h3C, 8'h00);
    wait_done(0, "shr0");
    issue(4'd14, 8'h90, 8'h02);
    wait_done(2, "asr");
    issue(4'd12, 8'hB5, 8'h03);
    wait_done(3, "shr3");

    // Plain logic ops over one operand pair.
    foreach (lops[i]) begin
      issue(lops[i], 8'hC5, 8'h3A);
      wait_done(0, $sformatf("logic_op%0d", lops[i]));
    end

    // NZ follows in_a one edge later even while the shifter is busy.
    issue(4'd11, 8'h01, 8'h07);
    for (int i = 0; i < 6; i++) begin
      in_a = (i % 2 == 1) ? 8'h40 : 8'h00;
      @(negedge clk);
      check($sformatf("nz_%0d", i), nz, (i % 2 == 1));
    end
    wait_done(1, "shl7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
